// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the iterative RV32M multiply/divide unit.
// Optional build macro (used by ex_muldiv_unit): MULDIV_FAST_MUL_EN.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only signed dividend whose negation overflows
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Radix-2 shift/add multiply and restoring-divide datapath on unsigned magnitudes.
// acc holds {high, low}: product (high) / multiplier (low), or remainder (high) / quotient (low).
module muldiv_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     mag_a_i,
    input  logic [XLEN-1:0]     mag_b_i,
    output logic [2*XLEN-1:0]   acc_next_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] step_val;

    // The shifted partial remainder needs one extra bit when the divisor exceeds 2^(XLEN-1)
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
    assign trial     = rem_shift - {1'b0, operand_q};

    always_comb begin
        step_val = acc_q;
        if (is_div_i) begin
            step_val = {(trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~trial[XLEN]};
        end else begin
            step_val = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        acc_d     = acc_q;
        operand_d = operand_q;
        if (load_i) begin
            acc_d     = {{XLEN{1'b0}}, mag_a_i};
            operand_d = mag_b_i;
        end else if (step_i) begin
            acc_d = step_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            operand_q <= '0;
        end else begin
            acc_q     <= acc_d;
            operand_q <= operand_d;
        end
    end

    assign acc_next_o = step_val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: FSM, step counter, sign fix-up and stall/done handshake.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplies instead of the iterative path.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        op_rd_q, op_rd_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              in_is_div, div_by_zero, div_ovf;
    logic              dp_load, dp_step;
    logic [2*XLEN-1:0] dp_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, calc_result;

    assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    assign b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    assign sign_a   = a_signed & op_a_i[XLEN-1];
    assign sign_b   = b_signed & op_b_i[XLEN-1];
    assign mag_a    = sign_a ? -op_a_i : op_a_i;
    assign mag_b    = sign_b ? -op_b_i : op_b_i;

    assign in_is_div   = f3_is_div(funct3_i);
    assign div_by_zero = (op_b_i == '0);
    assign div_ovf     = !funct3_i[0] && (op_a_i == XLEN'(DIV_OVF_DIVIDEND)) && (op_b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]          fast_result;

    assign fast_a      = {{XLEN{sign_a}}, op_a_i};
    assign fast_b      = {{XLEN{sign_b}}, op_b_i};
    assign fast_prod   = fast_a * fast_b;
    assign fast_result = (funct3_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dp_load),
        .step_i     (dp_step),
        .is_div_i   (f3_is_div(funct3_q)),
        .mag_a_i    (mag_a),
        .mag_b_i    (mag_b),
        .acc_next_o (dp_next)
    );

    // Fix-up works on the value the final step produces, so the result is registered on entry to DONE
    assign prod_fix = neg_quot_q ? -dp_next : dp_next;
    assign quot_fix = neg_quot_q ? -dp_next[XLEN-1:0] : dp_next[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? -dp_next[2*XLEN-1:XLEN] : dp_next[2*XLEN-1:XLEN];

    always_comb begin
        calc_result = prod_fix[2*XLEN-1:XLEN];
        if (f3_is_div(funct3_q)) begin
            calc_result = funct3_q[1] ? rem_fix : quot_fix;
        end else if (funct3_q == F3_MUL) begin
            calc_result = prod_fix[XLEN-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        op_rd_d    = op_rd_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        rd_d       = rd_q;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    funct3_d   = funct3_i;
                    op_rd_d    = rd_i;
                    neg_quot_d = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    cnt_d      = '0;
                    if (in_is_div && div_by_zero) begin
                        state_d  = ST_DONE;
                        result_d = funct3_i[1] ? op_a_i : '1;
                        rd_d     = rd_i;
                    end else if (in_is_div && div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = funct3_i[1] ? '0 : XLEN'(DIV_OVF_DIVIDEND);
                        rd_d     = rd_i;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!in_is_div) begin
                        state_d  = ST_DONE;
                        result_d = fast_result;
                        rd_d     = rd_i;
`endif
                    end else begin
                        state_d = ST_CALC;
                        dp_load = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        result_d = calc_result;
                        rd_d     = op_rd_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            funct3_q   <= '0;
            op_rd_q    <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            op_rd_q    <= op_rd_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
        end
    end

    assign done_o   = (state_q == ST_DONE);
    assign stall_o  = start_i & ~done_o;
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M cases, flush, reset and random ops.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .rd_i     (rd_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        up;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        up = {32'b0, a} * {32'b0, b};
        r  = '0;
        case (f3)
            3'd0: r = up[31:0];
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: r = up[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Called and returns at posedge+1; leaves start_i low in the IDLE cycle after DONE.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e, o;
        int   cyc;
        int   stall_cnt;
        bit   got;
        e.res = exp_res;
        e.rd  = rd;
        e.lat = exp_lat(f3, a, b);
        sb_q.push_back(e);
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        rd_i     = rd;
        #1;
        stall_cnt = stall_o ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) got = 1'b1;
            else if (stall_o) stall_cnt++;
        end
        o = sb_q.pop_front();
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_result"}, result_o, o.res);
            chk({name, "_rd"}, {27'd0, rd_o}, {27'd0, o.rd});
            chk({name, "_latency"}, 32'(cyc), 32'(o.lat));
            chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(o.lat));
            chk({name, "_stall_at_done"}, {31'd0, stall_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk({name, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        chk({name, "_result_hold"}, result_o, o.res);
        $display("op %-14s f3=%0d a=%h b=%h rd=%0d -> result=%h rd_o=%0d latency=%0d",
                 name, f3, a, b, rd, result_o, rd_o, cyc);
        start_i = 1'b0;
    endtask

    initial begin
        int done_seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; op_a_i = '0; op_b_i = '0; rd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", {27'd0, rd_o}, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
        run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
        run_op("remu_bigdiv", 3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h7FFF_FFFE);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd15, 32'd5);
        run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);

        // Flush a DIVU while the step counter sits at 10
        start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd20;
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) done_seen++;
        end
        chk("flush_no_done", 32'(done_seen), 32'd0);
        chk("flush_rd_kept", {27'd0, rd_o}, 32'd18);
        $display("op flush_divu    flushed at cnt=10, done pulses after flush=%0d", done_seen);
        run_op("mul_after_fl", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12);

        // Asynchronous reset in the middle of a divide
        start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd7; rd_i = 5'd22;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", {27'd0, rd_o}, 32'd0);
        start_i = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        $display("op midcalc_reset  result=%h rd_o=%0d done=%0d", result_o, rd_o, done_o);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("div_after_rst", 3'd4, 32'd1000, 32'd7, 5'd23, 32'd142);
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd24, 32'd12);

        for (int i = 0; i < 24; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 6 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op("random", rf3, ra, rb, 5'(i + 1), ref_res(rf3, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
